teclado_cmd_fifo: RTL and testbench

- Sits directly downstream of the PS/2 keyboard receiver and upstream of the PicoBlaze controller.
- Captures each key the receiver flags (`letra` + `new_data`), translates the scan code to a compact command code and acknowledges it by pulsing `new_data_pico`.
- Buffers commands in a small FIFO that the PicoBlaze drains through its input-port interface (`port_id`/`read_strobe`).
- Decouples keystroke arrival from firmware polling latency so no keypress is lost while the processor is busy with RTC traffic.

---
 rtl/teclado_cmd_fifo.sv | 141 ++++++++++++++
 tb/tb_teclado_cmd_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/teclado_cmd_fifo.sv
// Keyboard-to-PicoBlaze command FIFO: translates PS/2 scan codes to command codes,
// acknowledges the receiver and queues commands. Optional macro: TECLADO_ESC_FLUSH_EN.
module teclado_cmd_fifo #(
  parameter int          DEPTH_LOG2  = 2,
  parameter logic [7:0]  PORT_DATA   = 8'h0A,
  parameter logic [7:0]  PORT_STATUS = 8'h0B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] letra,
  input  logic       new_data,
  output logic       new_data_pico,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] dato_pico,
  output logic       fifo_full,
  output logic       fifo_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {ESPERA, ACK, LIBERA} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [7:0]            r_dato;

  logic [7:0]            w_cmd;
  logic                  w_valid;
  logic                  w_capture;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf_set;
  logic                  w_status_rd;
  logic                  w_flush;
  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_waddr;

  always_comb begin
    w_cmd = 8'h00;
    case (letra)
      8'h2B: w_cmd = 8'h01;
      8'h33: w_cmd = 8'h02;
      8'h2C: w_cmd = 8'h03;
      8'h75: w_cmd = 8'h04;
      8'h74: w_cmd = 8'h05;
      8'h6B: w_cmd = 8'h06;
      8'h72: w_cmd = 8'h07;
      8'h76: w_cmd = 8'h08;
      default: w_cmd = 8'h00;
    endcase
  end

  assign w_valid    = (w_cmd != 8'h00);
  assign fifo_full  = (r_count == C_FULL);
  assign fifo_empty = (r_count == '0);

  assign w_capture   = (r_state == ESPERA) && new_data;
  assign w_pop       = read_strobe && (port_id == PORT_DATA) && !fifo_empty;
  assign w_status_rd = read_strobe && (port_id == PORT_STATUS);

`ifdef TECLADO_ESC_FLUSH_EN
  assign w_flush = w_capture && (w_cmd == 8'h08);
`else
  assign w_flush = 1'b0;
`endif

  // A pop in the same cycle frees a slot, so a push while full is still accepted.
  assign w_push    = w_capture && w_valid && !w_flush && (!fifo_full || w_pop);
  assign w_ovf_set = w_capture && w_valid && !w_flush && fifo_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ESPERA;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ESPERA:  if (new_data) w_state_next = ACK;
      ACK:     w_state_next = LIBERA;
      LIBERA:  if (!new_data) w_state_next = ESPERA;
      default: w_state_next = ESPERA;
    endcase
  end

  assign new_data_pico = (r_state == ACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      // ESC becomes the sole entry, written at slot 0.
      r_rd_ptr   <= '0;
      r_wr_ptr   <= DEPTH_LOG2'(1);
      r_count    <= (DEPTH_LOG2+1)'(1);
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)        r_overflow <= 1'b1;
      else if (w_status_rd) r_overflow <= 1'b0;
    end
  end

  assign w_we    = w_push || w_flush;
  assign w_waddr = w_flush ? '0 : r_wr_ptr;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_cmd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dato <= 8'h00;
    end else if (port_id == PORT_DATA) begin
      r_dato <= fifo_empty ? 8'h00 : r_mem[r_rd_ptr];
    end else if (port_id == PORT_STATUS) begin
      r_dato <= {5'b0, r_overflow, fifo_full, ~fifo_empty};
    end else begin
      r_dato <= 8'h00;
    end
  end

  assign dato_pico = r_dato;

endmodule

// File: tb/tb_teclado_cmd_fifo.sv
// Self-checking bench for teclado_cmd_fifo: table of scan codes plus hand-built
// sequences; expected FIFO contents kept in a scoreboard queue.
module tb_teclado_cmd_fifo;
  localparam logic [7:0] P_DATA   = 8'h0A;
  localparam logic [7:0] P_STATUS = 8'h0B;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] letra;
  logic       new_data;
  logic       new_data_pico;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] dato_pico;
  logic       fifo_full;
  logic       fifo_empty;

  teclado_cmd_fifo #(.DEPTH_LOG2(2), .PORT_DATA(P_DATA), .PORT_STATUS(P_STATUS)) dut (
    .clk(clk), .reset(reset), .letra(letra), .new_data(new_data),
    .new_data_pico(new_data_pico), .port_id(port_id), .read_strobe(read_strobe),
    .dato_pico(dato_pico), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q_exp[$];
  logic       m_ovf;

  typedef struct {
    logic [7:0] code;
    logic [7:0] cmd;   // 00 marks an invalid code
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end else begin
      $display("ok   %s: %02h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_status();
    return {5'b0, m_ovf, (q_exp.size() == 4), (q_exp.size() != 0)};
  endfunction

  function automatic void model_key(input logic [7:0] cmd);
    if (cmd == 8'h00) return;
`ifdef TECLADO_ESC_FLUSH_EN
    if (cmd == 8'h08) begin
      q_exp.delete();
      m_ovf = 1'b0;
      q_exp.push_back(8'h08);
      return;
    end
`endif
    if (q_exp.size() < 4) q_exp.push_back(cmd);
    else                  m_ovf = 1'b1;
  endfunction

  task automatic do_reset();
    reset = 1'b1; new_data = 1'b0; read_strobe = 1'b0; port_id = 8'h00; letra = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    q_exp.delete();
    m_ovf = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] code, input logic [7:0] cmd);
    letra = code;
    new_data = 1'b1;
    check("ack_before_capture", new_data_pico, 8'h00);
    tick();
    model_key(cmd);
    check("ack_pulse", new_data_pico, 8'h01);
    check("empty_after_capture", fifo_empty, (q_exp.size() == 0));
    check("full_after_capture", fifo_full, (q_exp.size() == 4));
    new_data = 1'b0;
    tick();
    check("ack_single_cycle", new_data_pico, 8'h00);
    tick();
  endtask

  task automatic read_data(input string name);
    logic [7:0] exp;
    port_id = P_DATA;
    tick();
    exp = (q_exp.size() != 0) ? q_exp[0] : 8'h00;
    check(name, dato_pico, exp);
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    port_id = 8'h00;
    if (q_exp.size() != 0) void'(q_exp.pop_front());
  endtask

  task automatic read_status(input string name);
    port_id = P_STATUS;
    tick();
    check(name, dato_pico, m_status());
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
    port_id = 8'h00;
    m_ovf = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    vecs[0]  = '{8'h2B, 8'h01};
    vecs[1]  = '{8'h33, 8'h02};
    vecs[2]  = '{8'h2C, 8'h03};
    vecs[3]  = '{8'h75, 8'h04};
    vecs[4]  = '{8'h74, 8'h05};
    vecs[5]  = '{8'h6B, 8'h06};
    vecs[6]  = '{8'h72, 8'h07};
    vecs[7]  = '{8'h76, 8'h08};
    vecs[8]  = '{8'h1C, 8'h00};
    vecs[9]  = '{8'h00, 8'h00};
    vecs[10] = '{8'h2A, 8'h00};
    vecs[11] = '{8'hF0, 8'h00};

    do_reset();
    check("rst_empty", fifo_empty, 8'h01);
    check("rst_full", fifo_full, 8'h00);
    check("rst_ack", new_data_pico, 8'h00);
    check("rst_dato", dato_pico, 8'h00);
    read_status("rst_status");

    // Each code alone: capture, pop, FIFO empty again.
    for (int i = 0; i < 12; i++) begin
      send_key(vecs[i].code, vecs[i].cmd);
      read_data("tbl_pop");
      check("tbl_empty_after_pop", fifo_empty, 8'h01);
    end

    // Fill past capacity, sticky overflow, status clears it.
    send_key(8'h33, 8'h02);
    send_key(8'h2C, 8'h03);
    send_key(8'h75, 8'h04);
    send_key(8'h74, 8'h05);
    send_key(8'h72, 8'h07);
    check("ovf_full", fifo_full, 8'h01);
    read_status("ovf_status_set");
    read_status("ovf_status_cleared");
    for (int i = 0; i < 4; i++) read_data("ovf_drain");
    read_data("pop_on_empty");
    check("empty_after_empty_pop", fifo_empty, 8'h01);

    send_key(8'h1C, 8'h00);
    read_status("invalid_status");

    // new_data held high: only one capture and one ack.
    letra = 8'h6B;
    new_data = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) model_key(8'h06);
      if (new_data_pico) pulses++;
    end
    new_data = 1'b0;
    tick();
    tick();
    check("hold_ack_pulses", 8'(pulses), 8'h01);
    read_data("hold_pop");
    check("hold_empty", fifo_empty, 8'h01);

    // Push and pop in the same cycle while full.
    send_key(8'h2B, 8'h01);
    send_key(8'h33, 8'h02);
    send_key(8'h2C, 8'h03);
    send_key(8'h75, 8'h04);
    port_id = P_DATA;
    tick();
    check("simul_head", dato_pico, q_exp[0]);
    read_strobe = 1'b1;
    letra = 8'h72;
    new_data = 1'b1;
    tick();
    void'(q_exp.pop_front());
    model_key(8'h07);
    check("simul_ack", new_data_pico, 8'h01);
    check("simul_full", fifo_full, 8'h01);
    read_strobe = 1'b0;
    new_data = 1'b0;
    port_id = 8'h00;
    tick();
    tick();
    read_status("simul_status");
    for (int i = 0; i < 4; i++) read_data("simul_drain");
    check("simul_empty", fifo_empty, 8'h01);

    // ESC after three queued commands.
    send_key(8'h2B, 8'h01);
    send_key(8'h33, 8'h02);
    send_key(8'h2C, 8'h03);
    send_key(8'h76, 8'h08);
    check("esc_not_empty", fifo_empty, 8'h00);
    for (int i = 0; i < 4; i++) if (q_exp.size() != 0) read_data("esc_drain");
    check("esc_empty", fifo_empty, 8'h01);

    // Reset mid-operation with new_data still high recaptures the key.
    send_key(8'h2B, 8'h01);
    send_key(8'h33, 8'h02);
    letra = 8'h6B;
    new_data = 1'b1;
    reset = 1'b1;
    tick();
    check("midrst_ack", new_data_pico, 8'h00);
    check("midrst_empty", fifo_empty, 8'h01);
    reset = 1'b0;
    q_exp.delete();
    m_ovf = 1'b0;
    tick();
    model_key(8'h06);
    check("midrst_recapture_ack", new_data_pico, 8'h01);
    new_data = 1'b0;
    tick();
    tick();
    read_data("midrst_pop");
    check("midrst_final_empty", fifo_empty, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
